// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - instruction decode/control stage with multi-cycle mul issue FSM
`timescale 1ns/1ps
module decode_ctrl_stage #(
  parameter int          NUM_IO     = 3,
  parameter logic [11:0] IO_BASE    = 12'hF00,
  parameter int          MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              stall_in,
  input  logic              flush,
  output logic [3:0]        aluop,
  output logic [1:0]        regsel,
  output logic              alusrc,
  output logic              regwrite,
  output logic [NUM_IO-1:0] gpio_we,
  output logic              is_branch,
  output logic              is_jal,
  output logic              is_jalr,
  output logic [2:0]        br_funct3,
  output logic              illegal,
  output logic              ex_valid,
  output logic              stall_req
);

  typedef struct packed {
    logic              illegal;
    logic [3:0]        aluop;
    logic [1:0]        regsel;
    logic              alusrc;
    logic              regwrite;
    logic [NUM_IO-1:0] gpio_we;
    logic              is_branch;
    logic              is_jal;
    logic              is_jalr;
    logic [2:0]        br_funct3;
  } ctrl_t;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [11:0] w_csr_off;
  logic        w_ok;
  logic [3:0]  w_op;
  logic        w_is_mul;
  logic        w_accept;
  ctrl_t       w_dec;
  logic        w_unused_bits;

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  ctrl_t       r_out;
  ctrl_t       r_hold;
  logic        r_ex_valid;

  assign w_opcode      = instr[6:0];
  assign w_f3          = instr[14:12];
  assign w_f7          = instr[31:25];
  assign w_csr_off     = instr[31:20] - IO_BASE;
  assign w_unused_bits = ^{instr[19:15], instr[11:7]};

  always_comb begin
    w_dec         = '0;
    w_dec.illegal = 1'b1;
    w_ok          = 1'b0;
    w_op          = 4'b0000;
    w_is_mul      = 1'b0;
    case (w_opcode)
      7'h33: begin
        w_ok = 1'b1;
        case ({w_f7, w_f3})
          {7'h00, 3'b000}: w_op = 4'b0011;
          {7'h00, 3'b001}: w_op = 4'b1000;
          {7'h00, 3'b010}: w_op = 4'b1100;
          {7'h00, 3'b011}: w_op = 4'b1101;
          {7'h00, 3'b100}: w_op = 4'b0010;
          {7'h00, 3'b101}: w_op = 4'b1001;
          {7'h00, 3'b110}: w_op = 4'b0001;
          {7'h00, 3'b111}: w_op = 4'b0000;
          {7'h20, 3'b000}: w_op = 4'b0100;
          {7'h20, 3'b101}: w_op = 4'b1010;
          {7'h01, 3'b000}: begin w_op = 4'b0101; w_is_mul = 1'b1; end
          {7'h01, 3'b001}: begin w_op = 4'b0110; w_is_mul = 1'b1; end
          {7'h01, 3'b011}: begin w_op = 4'b0111; w_is_mul = 1'b1; end
          default:         w_ok = 1'b0;
        endcase
        if (w_ok) begin
          w_dec.illegal  = 1'b0;
          w_dec.aluop    = w_op;
          w_dec.regsel   = 2'b10;
          w_dec.regwrite = 1'b1;
        end
      end
      7'h13: begin
        w_ok = 1'b1;
        case (w_f3)
          3'b000: w_op = 4'b0011;
          3'b010: w_op = 4'b1100;
          3'b011: w_op = 4'b1101;
          3'b100: w_op = 4'b0010;
          3'b110: w_op = 4'b0001;
          3'b111: w_op = 4'b0000;
          3'b001: begin w_op = 4'b1000; w_ok = (w_f7 == 7'h00); end
          default: begin
            // f3=101: shift kind is chosen by imm[11:5]
            w_op = (w_f7 == 7'h20) ? 4'b1010 : 4'b1001;
            w_ok = (w_f7 == 7'h00) || (w_f7 == 7'h20);
          end
        endcase
        if (w_ok) begin
          w_dec.illegal  = 1'b0;
          w_dec.aluop    = w_op;
          w_dec.alusrc   = 1'b1;
          w_dec.regsel   = 2'b10;
          w_dec.regwrite = 1'b1;
        end
      end
      7'h37: begin
        w_dec.illegal  = 1'b0;
        w_dec.regsel   = 2'b01;
        w_dec.regwrite = 1'b1;
      end
      7'h73: begin
        if (w_csr_off == 12'd0) begin
          w_dec.illegal  = 1'b0;
          w_dec.regsel   = 2'b00;
          w_dec.regwrite = 1'b1;
        end
        for (int k = 1; k < NUM_IO; k++) begin
          if (w_csr_off == 12'(k)) begin
            w_dec.illegal    = 1'b0;
            w_dec.gpio_we[k] = 1'b1;
          end
        end
      end
      7'h63: begin
        if (w_f3 != 3'b010 && w_f3 != 3'b011) begin
          w_dec.illegal   = 1'b0;
          w_dec.is_branch = 1'b1;
          w_dec.aluop     = 4'b0100;
          w_dec.br_funct3 = w_f3;
        end
      end
      7'h6F: begin
        w_dec.illegal  = 1'b0;
        w_dec.is_jal   = 1'b1;
        w_dec.regsel   = 2'b11;
        w_dec.regwrite = 1'b1;
      end
      7'h67: begin
        if (w_f3 == 3'b000) begin
          w_dec.illegal  = 1'b0;
          w_dec.is_jalr  = 1'b1;
          w_dec.alusrc   = 1'b1;
          w_dec.aluop    = 4'b0011;
          w_dec.regsel   = 2'b11;
          w_dec.regwrite = 1'b1;
        end
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  assign stall_req = (r_state == S_BUSY);
  assign w_accept  = instr_valid && !stall_in && !flush && !stall_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_out      <= '0;
      r_hold     <= '0;
      r_ex_valid <= 1'b0;
    end else if (flush) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_out      <= '0;
      r_hold     <= '0;
      r_ex_valid <= 1'b0;
    end else if (stall_in) begin
      r_state <= r_state;
    end else if (r_state == S_BUSY) begin
      // outputs stay a bubble until the held mul is released on the last count
      if (r_cnt == 4'd1) begin
        r_state    <= S_IDLE;
        r_cnt      <= 4'd0;
        r_out      <= r_hold;
        r_ex_valid <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end else if (w_accept) begin
      if (w_is_mul && (MUL_CYCLES > 1)) begin
        r_state    <= S_BUSY;
        r_cnt      <= 4'(MUL_CYCLES - 1);
        r_hold     <= w_dec;
        r_out      <= '0;
        r_ex_valid <= 1'b0;
      end else begin
        r_out      <= w_dec;
        r_ex_valid <= 1'b1;
      end
    end else begin
      r_out      <= '0;
      r_ex_valid <= 1'b0;
    end
  end

  assign aluop     = r_out.aluop;
  assign regsel    = r_out.regsel;
  assign alusrc    = r_out.alusrc;
  assign regwrite  = r_out.regwrite;
  assign gpio_we   = r_out.gpio_we;
  assign is_branch = r_out.is_branch;
  assign is_jal    = r_out.is_jal;
  assign is_jalr   = r_out.is_jalr;
  assign br_funct3 = r_out.br_funct3;
  assign illegal   = r_out.illegal;
  assign ex_valid  = r_ex_valid;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - self-checking bench for decode_ctrl_stage
`timescale 1ns/1ps
module tb_decode_ctrl_stage;

  localparam int MUL = 3;

  typedef struct packed {
    logic       illegal;
    logic       ex_valid;
    logic [3:0] aluop;
    logic [1:0] regsel;
    logic       alusrc;
    logic       regwrite;
    logic [2:0] gpio_we;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic [2:0] br_funct3;
  } out_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    out_t        o;
    bit          mul;
  } pat_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, instr_valid, stall_in, flush;
  logic [31:0] instr;
  logic [3:0]  aluop, m1_aluop;
  logic [1:0]  regsel, m1_regsel;
  logic        alusrc, regwrite, is_branch, is_jal, is_jalr, illegal, ex_valid, stall_req;
  logic        m1_alusrc, m1_regwrite, m1_is_branch, m1_is_jal, m1_is_jalr, m1_illegal;
  logic        m1_ex_valid, m1_stall_req;
  logic [2:0]  gpio_we, br_funct3, m1_gpio_we, m1_br_funct3;
  out_t        act, m1_act;

  int n_tests = 0;
  int n_fail  = 0;

  pat_t pats[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  decode_ctrl_stage #(.NUM_IO(3), .IO_BASE(12'hF00), .MUL_CYCLES(MUL)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .stall_in(stall_in), .flush(flush), .aluop(aluop), .regsel(regsel),
    .alusrc(alusrc), .regwrite(regwrite), .gpio_we(gpio_we), .is_branch(is_branch),
    .is_jal(is_jal), .is_jalr(is_jalr), .br_funct3(br_funct3), .illegal(illegal),
    .ex_valid(ex_valid), .stall_req(stall_req)
  );

  decode_ctrl_stage #(.NUM_IO(3), .IO_BASE(12'hF00), .MUL_CYCLES(1)) u_mul1 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .stall_in(stall_in), .flush(flush), .aluop(m1_aluop), .regsel(m1_regsel),
    .alusrc(m1_alusrc), .regwrite(m1_regwrite), .gpio_we(m1_gpio_we),
    .is_branch(m1_is_branch), .is_jal(m1_is_jal), .is_jalr(m1_is_jalr),
    .br_funct3(m1_br_funct3), .illegal(m1_illegal), .ex_valid(m1_ex_valid),
    .stall_req(m1_stall_req)
  );

  assign act = {illegal, ex_valid, aluop, regsel, alusrc, regwrite, gpio_we,
                is_branch, is_jal, is_jalr, br_funct3};
  assign m1_act = {m1_illegal, m1_ex_valid, m1_aluop, m1_regsel, m1_alusrc, m1_regwrite,
                   m1_gpio_we, m1_is_branch, m1_is_jal, m1_is_jalr, m1_br_funct3};

  function automatic out_t mk(logic ill, logic [3:0] op, logic [1:0] rs, logic src, logic rw,
                              logic [2:0] gp, logic br, logic jal, logic jalr, logic [2:0] f3);
    return {ill, 1'b1, op, rs, src, rw, gp, br, jal, jalr, f3};
  endfunction

  function automatic out_t ill_out();
    return mk(1'b1, 4'b0, 2'b0, 1'b0, 1'b0, 3'b0, 1'b0, 1'b0, 1'b0, 3'b0);
  endfunction

  task automatic check_out(input string name, input out_t got, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h required %05h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addp(input logic [31:0] mask, input logic [31:0] match, input out_t o, input bit mul);
    pat_t p;
    p.mask = mask; p.match = match; p.o = o; p.mul = mul;
    pats.push_back(p);
  endtask

  task automatic addv(input string n, input logic [31:0] i, input out_t e);
    vec_t v;
    v.name = n; v.instr = i; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] renc(logic [6:0] f7, logic [2:0] f3, logic [6:0] opc);
    return {f7, 10'b0, f3, 5'b0, opc};
  endfunction

  // Instruction-set description as mask/match rows; CSR addresses are resolved arithmetically.
  task automatic build_patterns();
    logic [31:0] rm;
    logic [31:0] im;
    logic [3:0]  rops [10];
    logic [6:0]  rf7  [10];
    logic [2:0]  rf3  [10];
    logic [2:0]  bf3  [6];
    rm = 32'hFE00707F;
    im = 32'h0000707F;
    rops = '{4'b0011, 4'b1000, 4'b1100, 4'b1101, 4'b0010, 4'b1001, 4'b0001, 4'b0000, 4'b0100, 4'b1010};
    rf7  = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20};
    rf3  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd5};
    for (int i = 0; i < 10; i++) begin
      addp(rm, renc(rf7[i], rf3[i], 7'h33), mk(0, rops[i], 2'b10, 0, 1, 0, 0, 0, 0, 0), 0);
      if (rf3[i] == 3'd1 || rf3[i] == 3'd5)
        addp(rm, renc(rf7[i], rf3[i], 7'h13), mk(0, rops[i], 2'b10, 1, 1, 0, 0, 0, 0, 0), 0);
      else if (rf7[i] == 7'h00)
        addp(im, renc(7'h00, rf3[i], 7'h13), mk(0, rops[i], 2'b10, 1, 1, 0, 0, 0, 0, 0), 0);
    end
    addp(rm, renc(7'h01, 3'd0, 7'h33), mk(0, 4'b0101, 2'b10, 0, 1, 0, 0, 0, 0, 0), 1);
    addp(rm, renc(7'h01, 3'd1, 7'h33), mk(0, 4'b0110, 2'b10, 0, 1, 0, 0, 0, 0, 0), 1);
    addp(rm, renc(7'h01, 3'd3, 7'h33), mk(0, 4'b0111, 2'b10, 0, 1, 0, 0, 0, 0, 0), 1);
    addp(32'h7F, 32'h37, mk(0, 4'b0000, 2'b01, 0, 1, 0, 0, 0, 0, 0), 0);
    addp(32'h7F, 32'h6F, mk(0, 4'b0000, 2'b11, 0, 1, 0, 0, 1, 0, 0), 0);
    addp(im, 32'h67, mk(0, 4'b0011, 2'b11, 1, 1, 0, 0, 0, 1, 0), 0);
    bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 6; i++)
      addp(im, renc(7'h00, bf3[i], 7'h63), mk(0, 4'b0100, 2'b00, 0, 0, 0, 1, 0, 0, 0), 0);
  endtask

  function automatic out_t model(input logic [31:0] ins, output bit mul);
    out_t o;
    int   k;
    o   = ill_out();
    mul = 1'b0;
    foreach (pats[i]) begin
      if ((ins & pats[i].mask) == pats[i].match) begin
        o   = pats[i].o;
        mul = pats[i].mul;
        if (o.is_branch) o.br_funct3 = ins[14:12];
      end
    end
    if (ins[6:0] == 7'h73) begin
      k = int'(ins[31:20]) - int'(12'hF00);
      if (k == 0)
        o = mk(0, 4'b0, 2'b00, 0, 1, 3'b000, 0, 0, 0, 0);
      else if (k >= 1 && k < 3)
        o = mk(0, 4'b0, 2'b00, 0, 0, 3'(1 << k), 0, 0, 0, 0);
    end
    return o;
  endfunction

  function automatic logic [31:0] gen_instr();
    int   r;
    pat_t p;
    r = int'($urandom % 8);
    if (r == 0) return $urandom;
    if (r == 1) return {12'hF00 + 12'($urandom % 5), 13'($urandom), 7'h73};
    p = pats[$urandom % pats.size()];
    return p.match | ($urandom & ~p.mask);
  endfunction

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_LUI = 32'h123452B7;

  initial begin
    out_t exp_add, exp_mul, exp_lui, m_out, m_hold, d;
    int   lat, m_left;
    bit   seen, is_mul;

    build_patterns();
    exp_add = mk(0, 4'b0011, 2'b10, 0, 1, 0, 0, 0, 0, 0);
    exp_mul = mk(0, 4'b0101, 2'b10, 0, 1, 0, 0, 0, 0, 0);
    exp_lui = mk(0, 4'b0000, 2'b01, 0, 1, 0, 0, 0, 0, 0);

    addv("add",      I_ADD,        exp_add);
    addv("sub",      32'h402081B3, mk(0, 4'b0100, 2'b10, 0, 1, 0, 0, 0, 0, 0));
    addv("sra",      32'h4020D1B3, mk(0, 4'b1010, 2'b10, 0, 1, 0, 0, 0, 0, 0));
    addv("sltu",     32'h0020B1B3, mk(0, 4'b1101, 2'b10, 0, 1, 0, 0, 0, 0, 0));
    addv("mulhsu",   32'h0220A1B3, ill_out());
    addv("andi",     32'h0FF0F093, mk(0, 4'b0000, 2'b10, 1, 1, 0, 0, 0, 0, 0));
    addv("addi",     32'hFFF00093, mk(0, 4'b0011, 2'b10, 1, 1, 0, 0, 0, 0, 0));
    addv("srai",     32'h4030D193, mk(0, 4'b1010, 2'b10, 1, 1, 0, 0, 0, 0, 0));
    addv("slli_bad", 32'h02109193, ill_out());
    addv("lui",      I_LUI,        exp_lui);
    addv("csr_f00",  32'hF00091F3, mk(0, 4'b0000, 2'b00, 0, 1, 3'b000, 0, 0, 0, 0));
    addv("csr_f02",  32'hF02091F3, mk(0, 4'b0000, 2'b00, 0, 0, 3'b100, 0, 0, 0, 0));
    addv("csr_f07",  32'hF07091F3, ill_out());
    addv("beq",      32'h00208063, mk(0, 4'b0100, 2'b00, 0, 0, 0, 1, 0, 0, 3'b000));
    addv("bgeu",     32'h0020F063, mk(0, 4'b0100, 2'b00, 0, 0, 0, 1, 0, 0, 3'b111));
    addv("br_f3_2",  32'h0020A063, ill_out());
    addv("jal",      32'h000000EF, mk(0, 4'b0000, 2'b11, 0, 1, 0, 0, 1, 0, 0));
    addv("jalr",     32'h000100E7, mk(0, 4'b0011, 2'b11, 1, 1, 0, 0, 0, 1, 0));
    addv("jalr_f3",  32'h000110E7, ill_out());
    addv("opc_7f",   32'hFFFFFFFF, ill_out());

    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    step(); step();
    check_out("reset_outs", act, '0);
    check_int("reset_stall_req", int'(stall_req), 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      instr = vecs[i].instr; instr_valid = 1'b1;
      step();
      check_out(vecs[i].name, act, vecs[i].exp);
    end
    instr_valid = 1'b0;
    step();
    check_out("bubble", act, '0);

    // mul issue latency and blocking of the following instruction
    instr = I_MUL; instr_valid = 1'b1;
    step();
    check_int("mul_stall_c1", int'(stall_req), 1);
    check_int("mul_exv_c1", int'(ex_valid), 0);
    check_out("mul1_direct", m1_act, exp_mul);
    check_int("mul1_no_stall", int'(m1_stall_req), 0);
    instr = I_ADD;
    step();
    check_int("mul_stall_c2", int'(stall_req), 1);
    check_int("mul_exv_c2", int'(ex_valid), 0);
    step();
    check_int("mul_stall_c3", int'(stall_req), 0);
    check_out("mul_issue", act, exp_mul);
    step();
    check_out("add_after_mul", act, exp_add);
    instr_valid = 1'b0;
    step();

    // stall_in for two cycles mid-BUSY stretches the latency to 5
    instr = I_MUL; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; stall_in = 1'b1;
    step(); step();
    check_int("mul_hold_stall_req", int'(stall_req), 1);
    stall_in = 1'b0;
    lat = 3;
    while (!ex_valid && lat < 20) begin
      step();
      lat++;
    end
    check_int("mul_stalled_latency", lat, 5);
    check_out("mul_stalled_issue", act, exp_mul);
    step();

    // flush mid-BUSY: mul must never issue
    instr = I_MUL; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_out("flush_busy_outs", act, '0);
    check_int("flush_busy_stall_req", int'(stall_req), 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ex_valid) seen = 1'b1;
    end
    check_int("flushed_mul_issued", int'(seen), 0);

    // flush with a valid instruction discards it; stall_in holds outputs
    instr = I_ADD; instr_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    check_out("flush_discard", act, '0);
    step();
    check_out("add_pre_stall", act, exp_add);
    instr = I_LUI; stall_in = 1'b1;
    step(); step();
    check_out("stall_hold", act, exp_add);
    stall_in = 1'b0;
    step();
    check_out("lui_after_stall", act, exp_lui);

    // reset overrides BUSY and stall_in
    instr = I_MUL;
    step();
    instr_valid = 1'b0; rst_n = 1'b0; stall_in = 1'b1;
    step();
    check_out("rst_busy_outs", act, '0);
    check_int("rst_busy_stall_req", int'(stall_req), 0);
    rst_n = 1'b1; stall_in = 1'b0;
    step();
    check_out("post_rst_bubble", act, '0);

    // randomized traffic against the reference model
    m_out = '0; m_hold = '0; m_left = 0;
    for (int c = 0; c < 3000; c++) begin
      instr       = gen_instr();
      instr_valid = ($urandom % 4) != 0;
      stall_in    = ($urandom % 8) == 0;
      flush       = ($urandom % 24) == 0;
      check_int("rand_stall_req", int'(stall_req), (m_left > 0) ? 1 : 0);
      if (flush) begin
        m_left = 0; m_out = '0;
      end else if (stall_in) begin
        m_left = m_left;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_out = m_hold;
      end else if (instr_valid) begin
        d = model(instr, is_mul);
        if (is_mul) begin
          m_left = MUL - 1; m_hold = d; m_out = '0;
        end else begin
          m_out = d;
        end
      end else begin
        m_out = '0;
      end
      step();
      check_out("rand_outs", act, m_out);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 SHALL have parameter NUM_IO, default 3: number of CSR IO ports; port 0 is read-only (switches), ports 1..NUM_IO-1 are write ports.
REQ-002 SHALL have parameter IO_BASE, default 12'hF00: CSR address of IO port 0; port k is at IO_BASE+k.
REQ-003 SHALL have parameter MUL_CYCLES, default 3, range 1..15: issue latency of the mul/mulh/mulhu family.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset.
instr  in  32  fetched instruction.
instr_valid  in  1  instr is valid this cycle.
stall_in  in  1  downstream hold.
flush  in  1  squash held/incoming instruction.
aluop  out  4  ALU operation.
regsel  out  2  writeback source: 00 IO, 01 imm20, 10 ALU, 11 PC+4.
alusrc  out  1  0 = rs2, 1 = sign-extended imm12.
regwrite  out  1  register-file write enable.
gpio_we  out  NUM_IO  one-hot IO write enable; bit 0 is always 0.
is_branch, is_jal, is_jalr  out  1 each  control-transfer flags.
br_funct3  out  3  branch condition code.
illegal  out  1  undecodable instruction.
ex_valid  out  1  outputs describe a live instruction.
stall_req  out  1  upstream must hold instr.

Function
REQ-006 SHALL register all outputs except stall_req; a non-mul instruction appears on the outputs 1 cycle after acceptance.
REQ-007 SHALL accept instr on an edge only when instr_valid=1, stall_in=0, flush=0 and stall_req=0.
REQ-008 SHALL apply this priority at each edge: reset, then flush, then stall_in, then acceptance, then bubble.
REQ-009 On a bubble, SHALL drive ex_valid=0, with every other registered output 0.
REQ-010 On stall_in=1 without flush, SHALL hold all registers, including the FSM counter.
REQ-011 SHALL drive stall_req=1 exactly while the FSM is in BUSY.
REQ-012 SHALL decode opcode 0x33 as R-type with alusrc=0, regsel=10, regwrite=1 and this aluop map:
- and 0000, or 0001, xor 0010, add 0011, sub 0100
- mul 0101, mulh 0110, mulhu 0111
- sll 1000, srl 1001, sra 1010, slt 1100, sltu 1101.
REQ-013 SHALL decode opcode 0x13 as I-type with alusrc=1, regsel=10, regwrite=1 and this aluop map:
- addi, xori, ori, andi: same codes as REQ-012.
- slti 1100, sltiu 1101.
- slli requires imm[11:5]=0.
- srli requires imm[11:5]=0x00; srai requires imm[11:5]=0x20.
REQ-014 SHALL decode opcode 0x37 (lui) with regsel=01, regwrite=1.
REQ-015 SHALL decode opcode 0x73 (csrrw) with imm12=IO_BASE as regsel=00, regwrite=1.
REQ-016 SHALL decode opcode 0x73 with imm12=IO_BASE+k, 1<=k<NUM_IO, as gpio_we[k]=1, regwrite=0.
REQ-017 SHALL decode opcode 0x63 with funct3 not 010/011 as is_branch=1, alusrc=0, aluop=0100, br_funct3=funct3, regwrite=0.
REQ-018 SHALL decode opcode 0x6F as is_jal=1, regsel=11, regwrite=1.
REQ-019 SHALL decode opcode 0x67 with funct3=000 as is_jalr=1, alusrc=1, aluop=0011, regsel=11, regwrite=1.
REQ-020 SHALL decode any other opcode, funct7/funct3/imm combination, or CSR address as illegal=1, ex_valid=1, regwrite=0, gpio_we=0, branch and jump flags 0.
REQ-021 FSM states SHALL be IDLE and BUSY.
REQ-022 In IDLE with MUL_CYCLES>1, accepting a mul-family instruction SHALL:
- go to BUSY and load cnt=MUL_CYCLES-1;
- register that instruction's control fields;
- drive ex_valid=0.
REQ-023 In BUSY without stall_in or flush, SHALL decrement cnt each edge; the edge at which cnt=1 SHALL go to IDLE and set ex_valid=1 with the held fields.
REQ-024 Net effect of REQ-022/023: mul issues MUL_CYCLES cycles after acceptance, with no new instruction accepted meanwhile.
REQ-025 With MUL_CYCLES=1, mul SHALL behave as REQ-006 and never enter BUSY.
REQ-026 flush in BUSY SHALL return the FSM to IDLE with ex_valid=0, and the mul SHALL never issue.
REQ-027 flush and instr_valid together SHALL discard instr.

Reset
REQ-028 With rst_n=0 at an edge, SHALL:
- set the FSM to IDLE and cnt=0;
- clear every registered output to 0, including ex_valid and illegal;
- drive stall_req=0.
REQ-029 Reset SHALL override an in-flight BUSY and stall_in.

Verification
REQ-030 Reset, then add x3,x1,x2 (0x002081B3) valid -> next cycle: ex_valid=1, aluop=0011, regsel=10, alusrc=0, regwrite=1.
REQ-031 csrrw with imm12=0xF02 at defaults -> gpio_we=3'b100, regwrite=0; imm12=0xF07 -> illegal=1, gpio_we=0.
REQ-032 mul (funct7=1, funct3=000) at MUL_CYCLES=3 -> stall_req=1 for 2 cycles, then ex_valid=1 with aluop=0101; the following add is accepted only after that.
REQ-033 jalr with funct3=000 -> is_jalr=1, regsel=11, aluop=0011; jalr with funct3=001 -> illegal=1.
REQ-034 stall_in=1 for 2 cycles mid-BUSY extends the mul latency to 5; flush mid-BUSY -> IDLE, ex_valid=0, mul never issues.
REQ-035 rst_n=0 during BUSY -> next cycle all outputs 0 and stall_req=0.
